// File: rtl/add_seq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addseq_pkg
// Description : Shared types and constants for the add_seq_arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package addseq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/add_seq_arbiter_slice.sv
`default_nettype none
// ============================================================================
// Module      : adder_slice16
// Description : Combinational 16-bit adder with carry in/out; the shared
//               arithmetic resource of add_seq_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_slice16
  import addseq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/add_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_arbiter
// Description : Two-requester arbiter sequencing a WIDTH-bit add/sub over one
//               shared 16-bit slice, LS slice first. Optional macro
//               ADDSEQ_FIXED_PRIO_EN gives requester 0 fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq_arbiter
  import addseq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  localparam int              WORDS    = WIDTH / SLICE_W;
  localparam int              CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int              MSB      = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  state_e             state_q, state_d;
  req_id_t            rr_ptr_q, rr_ptr_d;
  req_id_t            op_id_q, op_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  req_id_t            rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_ovf_q, rsp_ovf_d;

  req_id_t            w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_sel_sub;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

`ifdef ADDSEQ_FIXED_PRIO_EN
  assign w_grant = req1_valid & ~req0_valid;
`else
  assign w_grant = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
`endif

  assign req0_ready = (state_q == IDLE) && req0_valid && (w_grant == 1'b0);
  assign req1_ready = (state_q == IDLE) && req1_valid && (w_grant == 1'b1);
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_a   = w_grant ? req1_a   : req0_a;
  assign w_sel_b   = w_grant ? req1_b   : req0_b;
  assign w_sel_sub = w_grant ? req1_sub : req0_sub;

  assign w_slice_a = a_q[SLICE_W*int'(cnt_q) +: SLICE_W];
  assign w_slice_b = b_q[SLICE_W*int'(cnt_q) +: SLICE_W];

  adder_slice16 u_slice (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (carry_q),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_id_d    = op_id_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_ovf_d  = rsp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
          a_d     = w_sel_a;
          b_d     = w_sel_b ^ {WIDTH{w_sel_sub}};
          carry_d = w_sel_sub;
          op_id_d = w_grant;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*int'(cnt_q) +: SLICE_W] = w_slice_sum;
        carry_d = w_slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          rsp_sum_d  = sum_d;
          rsp_cout_d = w_slice_cout;
          rsp_ovf_d  = (a_q[MSB] ^ b_q[MSB] ^ sum_d[MSB]) ^ w_slice_cout;
          rsp_id_d   = op_id_q;
          cnt_d      = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
`ifndef ADDSEQ_FIXED_PRIO_EN
          rr_ptr_d = ~rsp_id_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      op_id_q    <= 1'b0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      rsp_id_q   <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_id_q    <= op_id_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_seq_arbiter
// Description : Self-checking bench for add_seq_arbiter (WIDTH=64); honours
//               ADDSEQ_FIXED_PRIO_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_seq_arbiter;

  localparam int W   = 64;
  localparam int LAT = W / 16 + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b1;
  logic         rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_sum;

  add_seq_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic and the two's-complement sign rule.
  typedef struct { bit id; logic [W-1:0] sum; bit cout; bit ovf; } res_t;

  function automatic res_t model(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit sub);
    res_t r;
    logic [W:0] full;
    r.id = id;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      r.ovf  = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b};
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    end
    return r;
  endfunction

  res_t sb[$];
  bit   rr_m   = 1'b0;
  bit   busy_m = 1'b0;

  always @(negedge clk) begin
    res_t e;
    bit   g;
    if (rst) begin
      sb.delete();
      rr_m   = 1'b0;
      busy_m = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("ready_while_busy", 64'(busy_m), 64'd0);
        if (req0_valid && req1_valid) begin
`ifdef ADDSEQ_FIXED_PRIO_EN
          g = 1'b0;
`else
          g = rr_m;
`endif
          chk("grant", 64'(req1_ready), 64'(g));
        end
        g = req1_ready;
        sb.push_back(g ? model(1'b1, req1_a, req1_b, req1_sub)
                       : model(1'b0, req0_a, req0_b, req0_sub));
        busy_m = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_sum", rsp_sum, e.sum);
          chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
          chk("sb_ovf", 64'(rsp_ovf), 64'(e.ovf));
          chk("sb_id", 64'(rsp_id), 64'(e.id));
          rr_m = ~e.id;
        end
        busy_m = 1'b0;
      end
    end
  end

  task automatic run_op(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input bit s0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input bit s1,
                        input int stall,
                        output bit r_id, output logic [W-1:0] r_sum, output bit r_cout,
                        output bit r_ovf, output int lat);
    bit got;
    @(posedge clk); #1;
    rsp_ready  = 1'b1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end
    chk("accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready  = (stall == 0);
    got = 1'b0; lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = rsp_valid;
    end
    chk("rsp_arrive", 64'(got), 64'd1);
    r_id = rsp_id; r_sum = rsp_sum; r_cout = rsp_cout; r_ovf = rsp_ovf;
    repeat (stall) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  typedef struct {
    bit           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sub;
    logic [W-1:0] sum;
    bit           cout;
    bit           ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit           r_id, r_cout, r_ovf, got, c_cout, c_ovf, c_id;
    logic [W-1:0] r_sum, c_sum;
    int           lat;
    bit           exp_order[4];

    vecs[0] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sum", rsp_sum, 64'd0);
    chk("rst_flags", {61'd0, rsp_id, rsp_cout, rsp_ovf}, 64'd0);
    #1 rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      run_op(!vecs[i].id, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub,
             vecs[i].a, vecs[i].b, vecs[i].sub, 0, r_id, r_sum, r_cout, r_ovf, lat);
      chk($sformatf("vec%0d_sum", i), r_sum, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), 64'(r_cout), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(r_ovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_id", i), 64'(r_id), 64'(vecs[i].id));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
    end

    // Back-pressure: result held for 10 cycles, no request accepted meanwhile
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 64'h1234_5678_9ABC_DEF0; req0_b = 64'h1111; req0_sub = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req0_ready; end
    chk("hold_accept", 64'(got), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 64'h5; req1_b = 64'h6;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rsp_valid; end
    chk("hold_arrive", 64'(got), 64'd1);
    c_sum = rsp_sum; c_cout = rsp_cout; c_ovf = rsp_ovf; c_id = rsp_id;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_stable", {rsp_sum[60:0], rsp_cout, rsp_ovf, rsp_id},
          {c_sum[60:0], c_cout, c_ovf, c_id});
      chk("hold_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("idle_after_rsp", 64'(rsp_valid), 64'd0);

    // Arbitration order with both requesters valid
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef ADDSEQ_FIXED_PRIO_EN
      exp_order[i] = 1'b0;
`else
      exp_order[i] = (i % 2 == 1);
`endif
      run_op(1'b1, 1'b1, 64'(i + 1), 64'd10, 1'b0, 64'(i + 100), 64'd20, 1'b0, 0,
             r_id, r_sum, r_cout, r_ovf, lat);
      chk($sformatf("order%0d", i), 64'(r_id), 64'(exp_order[i]));
    end

    // Reset mid-RUN at slice counter 2
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 64'hFFFF_FFFF; req1_b = 64'h1; req1_sub = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = req1_ready; end
    chk("mid_accept", 64'(got), 64'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_sum", rsp_sum, 64'd0);
    chk("mid_rst_flags", {60'd0, rsp_id, rsp_cout, rsp_ovf, req0_ready | req1_ready}, 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    run_op(1'b1, 1'b0, 64'd3, 64'd4, 1'b0, 64'd0, 64'd0, 1'b0, 0, r_id, r_sum, r_cout, r_ovf, lat);
    chk("post_rst_sum", r_sum, 64'd7);
    chk("post_rst_flags", {61'd0, r_cout, r_ovf, r_id}, 64'd0);
    chk("post_rst_lat", 64'(lat), 64'(LAT));

    // Randomized traffic checked by the scoreboard
    for (int i = 0; i < 40; i++) begin
      int m;
      m = $urandom_range(1, 3);
      run_op(m[0], m[1], rnd64(), rnd64(), 1'($urandom_range(0, 1)),
             rnd64(), rnd64(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             r_id, r_sum, r_cout, r_ovf, lat);
      chk("rand_lat", 64'(lat), 64'(LAT));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
